// File: rtl/cordic_pipe_ctrl.sv
// Valid/ready flow controller for the CORDIC iteration pipeline: drives the
// per-stage enables, collapses bubbles, and carries a tag alongside each beat.
module cordic_pipe_ctrl #(
    parameter int ITERATION_CNT = 6,
    parameter int TAG_WIDTH     = 8
) (
    input  logic                                 aclk,
    input  logic                                 aresetn,
    input  logic                                 flush,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic [TAG_WIDTH-1:0]                 s_tag,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic [TAG_WIDTH-1:0]                 m_tag,
    output logic [ITERATION_CNT-1:0]             en,
    output logic [$clog2(ITERATION_CNT+1)-1:0]   occupancy,
    output logic                                 busy
);
    localparam int N     = ITERATION_CNT;
    localparam int OCC_W = $clog2(ITERATION_CNT + 1);

    logic [N-1:0]                v, iv, rdy;
    logic [N-1:0][TAG_WIDTH-1:0] t, t_in;
    logic                        in_hs, out_hs;

    assign iv[0]   = s_valid;
    assign t_in[0] = s_tag;
    for (genvar i = 1; i < N; i++) begin : g_link
        assign iv[i]   = v[i-1];
        assign t_in[i] = t[i-1];
    end

    // A stage can take a beat if it is empty or its occupant moves on this cycle.
    always_comb begin
        rdy      = '0;
        rdy[N-1] = ~v[N-1] | m_ready;
        for (int i = N - 2; i >= 0; i--)
            rdy[i] = ~v[i] | rdy[i+1];
    end

    assign en      = iv & rdy & {N{~flush}};
    assign s_ready = rdy[0] & ~flush;
    assign m_valid = v[N-1];
    assign m_tag   = t[N-1];
    assign busy    = (occupancy != '0);
    assign in_hs   = s_valid & s_ready;
    assign out_hs  = v[N-1] & m_ready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            v         <= '0;
            t         <= '0;
            occupancy <= '0;
        end else if (flush) begin
            v         <= '0;
            occupancy <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (rdy[i]) v[i] <= iv[i];
                if (en[i])  t[i] <= t_in[i];
            end
            if (in_hs && !out_hs)
                occupancy <= occupancy + OCC_W'(1);
            else if (!in_hs && out_hs)
                occupancy <= occupancy - OCC_W'(1);
        end
    end
endmodule

// File: tb/tb_cordic_pipe_ctrl.sv
// Directed bench for cordic_pipe_ctrl (N=6): streaming, backpressure, bubbles,
// simultaneous handshake, flush and asynchronous reset.
module tb_cordic_pipe_ctrl;
    logic       aclk, aresetn, flush, s_valid, s_ready, m_valid, m_ready, busy;
    logic [7:0] s_tag, m_tag;
    logic [5:0] en;
    logic [2:0] occupancy;
    int         checks, failures;

    cordic_pipe_ctrl #(.ITERATION_CNT(6), .TAG_WIDTH(8)) dut (
        .aclk(aclk), .aresetn(aresetn), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_tag(s_tag),
        .m_valid(m_valid), .m_ready(m_ready), .m_tag(m_tag),
        .en(en), .occupancy(occupancy), .busy(busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the active edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        int peak;
        checks = 0; failures = 0;
        aresetn = 1'b0; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_tag = 8'h00;
        #2;
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_busy",    32'(busy), 0);
        chk("rst_occ",     32'(occupancy), 0);
        chk("rst_m_tag",   32'(m_tag), 0);
        chk("rst_en",      32'(en), 0);
        chk("rst_s_ready", 32'(s_ready), 1);
        tick();
        aresetn = 1'b1;

        // Streaming: tags 1..10 back to back, first accept at end of cycle 1
        peak = 0;
        m_ready = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            s_valid = (c <= 10);
            s_tag   = 8'(c);
            #1;
            chk("stream_m_valid", 32'(m_valid), (c >= 7 && c <= 16) ? 1 : 0);
            if (c >= 7 && c <= 16) chk("stream_m_tag", 32'(m_tag), 32'(c - 6));
            if (int'(occupancy) > peak) peak = int'(occupancy);
            tick();
        end
        chk("stream_peak_occ", 32'(peak), 6);
        chk("stream_end_occ", 32'(occupancy), 0);

        // Fill under backpressure
        m_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            s_valid = 1'b1;
            s_tag   = 8'(8'h21 + k);
            #1;
            chk("fill_s_ready", 32'(s_ready), (k < 6) ? 1 : 0);
            if (k >= 6) begin
                chk("fill_en",  32'(en), 0);
                chk("fill_occ", 32'(occupancy), 6);
            end
            tick();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int j = 0; j < 7; j++) begin
            #1;
            chk("drain_m_valid", 32'(m_valid), (j < 6) ? 1 : 0);
            if (j < 6) chk("drain_m_tag", 32'(m_tag), 32'(8'h21 + j));
            tick();
        end

        // Bubble collapse: A, gap, B with output stalled
        m_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            s_valid = (c == 0 || c == 2);
            s_tag   = (c == 0) ? 8'hA1 : 8'hB2;
            #1;
            if (c >= 6) chk("bubble_en5_hold", 32'(en[5]), 0);
            if (c == 9) begin
                chk("bubble_m_valid", 32'(m_valid), 1);
                chk("bubble_m_tag",   32'(m_tag), 32'h00A1);
                chk("bubble_occ",     32'(occupancy), 2);
                chk("bubble_en",      32'(en), 0);
            end
            tick();
        end
        m_ready = 1'b1;
        #1;
        chk("bubble_out_a", 32'(m_tag), 32'h00A1);
        tick();
        #1;
        chk("bubble_b_valid", 32'(m_valid), 1);
        chk("bubble_out_b",   32'(m_tag), 32'h00B2);
        tick();
        #1;
        chk("bubble_empty", 32'(m_valid), 0);

        // Simultaneous handshake on a full pipe
        m_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            s_valid = 1'b1;
            s_tag   = 8'(8'h40 + k);
            tick();
        end
        m_ready = 1'b1;
        for (int j = 0; j < 20; j++) begin
            s_valid = 1'b1;
            s_tag   = 8'(8'h46 + j);
            #1;
            chk("simul_s_ready", 32'(s_ready), 1);
            chk("simul_occ",     32'(occupancy), 6);
            chk("simul_en",      32'(en), 32'h3F);
            chk("simul_m_tag",   32'(m_tag), 32'(8'h40 + j));
            tick();
        end
        s_valid = 1'b0;
        for (int j = 0; j < 6; j++) begin
            #1;
            chk("simul_drain_tag", 32'(m_tag), 32'(8'h54 + j));
            tick();
        end

        // Flush with 4 beats in flight
        m_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            s_valid = 1'b1;
            s_tag   = 8'(8'h61 + k);
            tick();
        end
        flush = 1'b1; s_valid = 1'b1; s_tag = 8'h99;
        #1;
        chk("flush_occ_before", 32'(occupancy), 4);
        chk("flush_en",         32'(en), 0);
        chk("flush_s_ready",    32'(s_ready), 0);
        tick();
        flush = 1'b0; s_valid = 1'b1; s_tag = 8'h77; m_ready = 1'b1;
        #1;
        chk("flush_m_valid", 32'(m_valid), 0);
        chk("flush_occ",     32'(occupancy), 0);
        chk("flush_busy",    32'(busy), 0);
        tick();
        s_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            #1;
            chk("post_flush_m_valid", 32'(m_valid), (c == 6) ? 1 : 0);
            if (c == 6) chk("post_flush_m_tag", 32'(m_tag), 32'h0077);
            tick();
        end

        // Asynchronous reset with 3 beats in flight
        m_ready = 1'b0;
        for (int c = 0; c < 11; c++) begin
            s_valid = (c < 3);
            s_tag   = 8'(8'h81 + c);
            tick();
        end
        m_ready = 1'b1;
        #1;
        chk("prerst_m_valid", 32'(m_valid), 1);
        chk("prerst_occ",     32'(occupancy), 3);
        chk("prerst_en",      32'(en), 32'h30);
        #1;
        aresetn = 1'b0;
        #1;
        chk("arst_m_valid", 32'(m_valid), 0);
        chk("arst_busy",    32'(busy), 0);
        chk("arst_occ",     32'(occupancy), 0);
        chk("arst_en",      32'(en), 0);
        tick();
        #2;
        aresetn = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            #1;
            chk("postrst_m_valid", 32'(m_valid), 0);
        end
        chk("postrst_occ", 32'(occupancy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
